// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the scoreboarded register file.
package regfile_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-bit vector: one bit per register, set by reservations, cleared by writes and the sweep.
module regfile_scoreboard #(
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int AW   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set,
  input  logic [AW-1:0]     set_addr,
  input  logic              clr,
  input  logic [AW-1:0]     clr_addr,
  input  logic              wipe,
  input  logic [AW-1:0]     wipe_addr,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy
);
  logic [NREG-1:0] busy;

  // Set is applied last so a same-cycle write and reservation leaves the bit set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (wipe) busy[wipe_addr] <= 1'b0;
      if (clr) busy[clr_addr] <= 1'b0;
      if (set && set_addr != '0) busy[set_addr] <= 1'b1;
    end
  end

  always_comb begin
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_busy[i] = busy[rd_addr[i*AW +: AW]];
    end
  end
endmodule

// File: rtl/regfile_sb.sv
// Register file with per-register pending bits, optional write-to-read bypass and a sequential clear.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [NRD*$clog2(NREG)-1:0] rd_addr,
  output logic [NRD*XLEN-1:0]         rd_data,
  output logic [NRD-1:0]              rd_busy,
  input  logic                        we,
  input  logic [$clog2(NREG)-1:0]     wr_addr,
  input  logic [XLEN-1:0]             wr_data,
  input  logic                        rsv_valid,
  input  logic [$clog2(NREG)-1:0]     rsv_addr,
  input  logic                        clr_req,
  output logic                        ready
);
  localparam int AW = $clog2(NREG);

  state_t          state;
  logic [AW-1:0]   cnt;
  logic [XLEN-1:0] regs [NREG];
  logic [NRD-1:0]  sb_busy;
  logic            do_wr;
  logic            do_rsv;
  logic            do_wipe;

  assign ready   = (state == IDLE);
  assign do_wr   = en && ready && we && (wr_addr != '0);
  assign do_rsv  = en && ready && rsv_valid && (rsv_addr != '0);
  assign do_wipe = en && (state == CLEAR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (en) begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state <= CLEAR;
            cnt   <= AW'(1);
          end
        end
        CLEAR: begin
          if (cnt == AW'(NREG - 1)) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Register 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else begin
      if (do_wr) regs[wr_addr] <= wr_data;
      if (do_wipe) regs[cnt] <= '0;
    end
  end

  regfile_scoreboard #(
    .NREG (NREG),
    .NRD  (NRD),
    .AW   (AW)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .set       (do_rsv),
    .set_addr  (rsv_addr),
    .clr       (do_wr),
    .clr_addr  (wr_addr),
    .wipe      (do_wipe),
    .wipe_addr (cnt),
    .rd_addr   (rd_addr),
    .rd_busy   (sb_busy)
  );

  // Forwarded reads report the post-edge busy state: only a same-cycle reservation keeps it set.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      if (en) begin
        if (BYPASS != 0 && do_wr && wr_addr == rd_addr[i*AW +: AW]) begin
          rd_data[i*XLEN +: XLEN] = wr_data;
          rd_busy[i]              = do_rsv && (rsv_addr == wr_addr);
        end else begin
          rd_data[i*XLEN +: XLEN] = regs[rd_addr[i*AW +: AW]];
          rd_busy[i]              = sb_busy[i];
        end
      end
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: vector table for read/write/reserve behaviour, hand sequences for clear, stall and reset.
module tb_regfile_sb;
  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [4:0]  ra0, ra1;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data, rd_data_nb;
  logic [1:0]  rd_busy, rd_busy_nb;
  logic        we;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rsv_valid;
  logic [4:0]  rsv_addr;
  logic        clr_req;
  logic        ready, ready_nb;

  int n_chk = 0;
  int n_err = 0;
  int low;

  assign rd_addr = {ra1, ra0};

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .en(en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .clr_req(clr_req), .ready(ready)
  );

  regfile_sb #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .en(en), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .clr_req(clr_req), .ready(ready_nb)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        rv;
    logic [4:0]  radr;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        b0;
    logic        b1;
    logic [31:0] nb0;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; wr_addr = a; wr_data = d;
    tick();
    we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; ra0 = '0; ra1 = '0; we = 1'b0; wr_addr = '0; wr_data = '0;
    rsv_valid = 1'b0; rsv_addr = '0; clr_req = 1'b0;
    #12;
    ra0 = 5'd5; ra1 = 5'd31;
    #1;
    chk("reset_ready", {31'd0, ready}, 32'd1);
    chk("reset_data", rd_data[31:0] | rd_data[63:32], 32'd0);
    chk("reset_busy", {30'd0, rd_busy}, 32'd0);
    rst = 1'b0;
    tick();

    //        we  wa     wd            rv  radr   a0     a1     d0            d1            b0 b1 nb0
    tv.push_back('{0, 5'd0, 32'h0,        0, 5'd0, 5'd0, 5'd1, 32'h0,        32'h0,        0, 0, 32'h0});
    tv.push_back('{1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 5'd5, 5'd3, 32'hDEADBEEF, 32'h0,        0, 0, 32'h0});
    tv.push_back('{0, 5'd0, 32'h0,        0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        0, 0, 32'hDEADBEEF});
    tv.push_back('{1, 5'd0, 32'h1234,     1, 5'd0, 5'd0, 5'd5, 32'h0,        32'hDEADBEEF, 0, 0, 32'h0});
    tv.push_back('{0, 5'd0, 32'h0,        0, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        0, 0, 32'h0});
    tv.push_back('{0, 5'd0, 32'h0,        1, 5'd7, 5'd7, 5'd5, 32'h0,        32'hDEADBEEF, 0, 0, 32'h0});
    tv.push_back('{0, 5'd0, 32'h0,        0, 5'd0, 5'd7, 5'd7, 32'h0,        32'h0,        1, 1, 32'h0});
    tv.push_back('{0, 5'd0, 32'h0,        0, 5'd0, 5'd7, 5'd5, 32'h0,        32'hDEADBEEF, 1, 0, 32'h0});
    tv.push_back('{1, 5'd7, 32'h55,       0, 5'd0, 5'd7, 5'd7, 32'h55,       32'h55,       0, 0, 32'h0});
    tv.push_back('{0, 5'd0, 32'h0,        0, 5'd0, 5'd7, 5'd7, 32'h55,       32'h55,       0, 0, 32'h55});
    tv.push_back('{1, 5'd9, 32'h55,       1, 5'd9, 5'd9, 5'd9, 32'h55,       32'h55,       1, 1, 32'h0});
    tv.push_back('{0, 5'd0, 32'h0,        0, 5'd0, 5'd9, 5'd7, 32'h55,       32'h55,       1, 0, 32'h55});
    tv.push_back('{1, 5'd3, 32'h3,        1, 5'd4, 5'd3, 5'd4, 32'h3,        32'h0,        0, 0, 32'h0});
    tv.push_back('{0, 5'd0, 32'h0,        0, 5'd0, 5'd4, 5'd3, 32'h0,        32'h3,        1, 0, 32'h0});
    tv.push_back('{1, 5'd4, 32'h44,       0, 5'd0, 5'd4, 5'd9, 32'h44,       32'h55,       0, 1, 32'h0});
    tv.push_back('{0, 5'd0, 32'h0,        0, 5'd0, 5'd4, 5'd9, 32'h44,       32'h55,       0, 1, 32'h44});

    for (int v = 0; v < tv.size(); v++) begin
      we = tv[v].we; wr_addr = tv[v].wa; wr_data = tv[v].wd;
      rsv_valid = tv[v].rv; rsv_addr = tv[v].radr; ra0 = tv[v].a0; ra1 = tv[v].a1;
      #1;
      chk($sformatf("vec%0d_d0", v), rd_data[31:0], tv[v].d0);
      chk($sformatf("vec%0d_d1", v), rd_data[63:32], tv[v].d1);
      chk($sformatf("vec%0d_b0", v), {31'd0, rd_busy[0]}, {31'd0, tv[v].b0});
      chk($sformatf("vec%0d_b1", v), {31'd0, rd_busy[1]}, {31'd0, tv[v].b1});
      chk($sformatf("vec%0d_nb0", v), rd_data_nb[31:0], tv[v].nb0);
      tick();
    end
    we = 1'b0; rsv_valid = 1'b0;

    // en=0 hides outputs and blocks writes
    en = 1'b0; ra0 = 5'd5; ra1 = 5'd9;
    #1;
    chk("en0_data", rd_data[31:0], 32'h0);
    chk("en0_busy", {30'd0, rd_busy}, 32'd0);
    chk("en0_ready", {31'd0, ready}, 32'd1);
    wr(5'd5, 32'hBAD0BAD0);
    en = 1'b1;
    #1;
    chk("en0_nowrite", rd_data[31:0], 32'hDEADBEEF);

    // Fill every register with its index, leave x10 pending, then sweep
    for (int r = 1; r < 32; r++) wr(5'(r), r);
    rsv_valid = 1'b1; rsv_addr = 5'd10; tick(); rsv_valid = 1'b0;
    ra0 = 5'd17; ra1 = 5'd10;
    #1;
    chk("fill_x17", rd_data[31:0], 32'd17);
    chk("fill_busy10", {31'd0, rd_busy[1]}, 32'd1);
    clr_req = 1'b1;
    #1;
    chk("clr_req_ready", {31'd0, ready}, 32'd1);
    tick();
    clr_req = 1'b0;
    we = 1'b1; wr_addr = 5'd2; wr_data = 32'hFFFF; rsv_valid = 1'b1; rsv_addr = 5'd2; ra0 = 5'd2;
    #1;
    chk("clear_nobypass", rd_data[31:0], 32'd2);
    low = 0;
    for (int k = 0; k < 100; k++) begin
      if (ready !== 1'b0) break;
      low++;
      tick();
      #1;
    end
    we = 1'b0; rsv_valid = 1'b0;
    chk("clear_len", low, 32'd31);
    for (int r = 0; r < 32; r++) begin
      ra0 = 5'(r); ra1 = 5'(r);
      #1;
      chk($sformatf("cleared_x%0d", r), rd_data[31:0], 32'd0);
      chk($sformatf("cleared_busy_x%0d", r), {31'd0, rd_busy[1]}, 32'd0);
    end
    tick();

    // Stall the sweep for five cycles: counter frozen, outputs zero, finish five cycles late
    wr(5'd31, 32'd31);
    ra0 = 5'd31;
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    low = 0;
    for (int k = 0; k < 200; k++) begin
      en = !(k >= 3 && k < 8);
      #1;
      if (ready !== 1'b0) break;
      low++;
      if (!en) chk($sformatf("stall_data_k%0d", k), rd_data[31:0], 32'd0);
      if (k == 8) chk("stall_x31_kept", rd_data[31:0], 32'd31);
      tick();
    end
    en = 1'b1;
    chk("stall_clear_len", low, 32'd36);
    #1;
    chk("stall_x31_cleared", rd_data[31:0], 32'd0);
    tick();

    // Asynchronous reset in the middle of a sweep
    wr(5'd20, 32'd20);
    rsv_valid = 1'b1; rsv_addr = 5'd25; tick(); rsv_valid = 1'b0;
    ra0 = 5'd20; ra1 = 5'd25;
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    #1;
    chk("pre_rst_ready", {31'd0, ready}, 32'd0);
    chk("pre_rst_x20", rd_data[31:0], 32'd20);
    chk("pre_rst_busy25", {31'd0, rd_busy[1]}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_data", rd_data[31:0] | rd_data[63:32], 32'd0);
    chk("rst_async_busy", {30'd0, rd_busy}, 32'd0);
    chk("rst_async_ready", {31'd0, ready}, 32'd1);
    #3;
    rst = 1'b0;
    tick();
    #1;
    chk("post_rst_ready", {31'd0, ready}, 32'd1);
    chk("post_rst_x20", rd_data[31:0], 32'd0);
    wr(5'd6, 32'h66);
    ra0 = 5'd6;
    #1;
    chk("post_rst_write", rd_data[31:0], 32'h66);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
